// File: rtl/mips_pkg.sv
// Shared fetch-path types and constants.
package mips_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with flush and a combinational head.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Flush wins over any push or pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC, credit-gated ROM requests and a
// {pc, instr} queue drained by decode through valid/ready.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic            inflight_q, inflight_d;
  logic            kill_q, kill_d;

  logic [CW-1:0]   count;
  logic            pop_c, push_c, req_c, credit_c;
  fetch_entry_t    wentry, head;

  assign pop_c    = o_valid & i_ready;
  // Queued plus outstanding entries may never exceed the queue depth.
  assign credit_c = (count + CW'(inflight_q) - CW'(pop_c)) < CW'(DEPTH);
  assign req_c    = i_rst_n & ~i_redirect & credit_c;
  assign push_c   = inflight_q & ~kill_q & ~i_redirect;

  always_comb begin
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = req_c;
    // Single-cycle ROM: a redirect always coincides with the response, so no kill is needed.
    kill_d     = 1'b0;
    if (i_redirect) begin
      pc_d = i_redirect_pc;
    end else if (req_c) begin
      pc_d      = pc_q + PC_STEP;
      resp_pc_d = pc_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q       <= RESET_PC;
      resp_pc_q  <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  always_comb begin
    wentry       = '0;
    wentry.pc    = resp_pc_q;
    wentry.instr = i_imem_rdata;
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .flush_i (i_redirect),
    .wdata_i (wentry),
    .count_o (count),
    .head_o  (head)
  );

  assign o_imem_req  = req_c;
  assign o_imem_addr = pc_q;
  assign o_valid     = (count != '0);
  assign o_pc        = head.pc;
  assign o_instr     = head.instr;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand-written corner sequences
// and a randomized run checked against a transaction-level fetch model.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] rpc = '0;
  logic        req;
  logic [31:0] addr;
  logic [31:0] rdata = '0;
  logic        valid;
  logic        ready = 1'b0;
  logic [31:0] hpc;
  logic [31:0] hinstr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_redirect    (redirect),
    .i_redirect_pc (rpc),
    .o_imem_req    (req),
    .o_imem_addr   (addr),
    .i_imem_rdata  (rdata),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_pc          (hpc),
    .o_instr       (hinstr)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  // Synchronous ROM, one-cycle read latency.
  always @(posedge clk) if (req) rdata <= rom_word(addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t v(input logic r, input logic rd, input logic [31:0] rp,
                             input logic eq, input logic [31:0] ea,
                             input logic ev, input logic [31:0] ep);
    vec_t t;
    t.ready = r; t.redir = rd; t.rpc = rp;
    t.e_req = eq; t.e_addr = ea; t.e_valid = ev; t.e_pc = ep;
    return t;
  endfunction

  // Entered at posedge+1 of the cycle matching row lo; leaves at posedge+1 after row hi.
  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      ready    = tbl[i].ready;
      redirect = tbl[i].redir;
      rpc      = tbl[i].rpc;
      @(negedge clk);
      chk($sformatf("row%0d_req", i), 32'(req), 32'(tbl[i].e_req));
      chk($sformatf("row%0d_addr", i), addr, tbl[i].e_addr);
      chk($sformatf("row%0d_valid", i), 32'(valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk($sformatf("row%0d_pc", i), hpc, tbl[i].e_pc);
        chk($sformatf("row%0d_instr", i), hinstr, rom_word(tbl[i].e_pc));
      end
      @(posedge clk); #1;
    end
    redirect = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_req"}, 32'(req), 32'd0);
    chk({tag, "_addr"}, addr, RESET_PC);
    chk({tag, "_pc"}, hpc, 32'd0);
    chk({tag, "_instr"}, hinstr, 32'd0);
  endtask

  // Reference model: delivered stream is consecutive PCs from the last
  // redirect target, fetch restarts the cycle after a redirect, and no more
  // than DEPTH fetched-but-undelivered instructions may exist.
  logic        mon_en = 1'b0;
  int          m_age;
  int          m_outst;
  logic [31:0] m_exp_pc;
  logic [31:0] m_fetch_pc;

  always @(negedge clk) begin
    if (!mon_en) begin
      m_age      = 0;
      m_outst    = 0;
      m_exp_pc   = RESET_PC;
      m_fetch_pc = RESET_PC;
    end else begin
      logic pop, e_req;
      chk("m_valid", 32'(valid), 32'(m_age >= 2));
      pop   = valid & ready;
      e_req = !redirect && ((m_outst - int'(pop)) < int'(DEPTH));
      if (pop && !redirect) begin
        chk("m_pc", hpc, m_exp_pc);
        chk("m_instr", hinstr, rom_word(m_exp_pc));
        m_exp_pc = m_exp_pc + 32'd4;
      end
      chk("m_req", 32'(req), 32'(e_req));
      if (e_req) chk("m_addr", addr, m_fetch_pc);
      if (redirect) begin
        m_age      = 0;
        m_outst    = 0;
        m_exp_pc   = rpc;
        m_fetch_pc = rpc;
      end else begin
        if (m_age < 100) m_age++;
        m_outst = m_outst + int'(e_req) - int'(pop);
        if (e_req) m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
  end

  initial begin
    logic [31:0] wexp [3];
    int nreq;
    int k;

    tbl[0]  = v(1'b1, 1'b0, 32'h0,   1'b1, 32'h00,  1'b0, 32'h0);
    tbl[1]  = v(1'b1, 1'b0, 32'h0,   1'b1, 32'h04,  1'b0, 32'h0);
    tbl[2]  = v(1'b1, 1'b0, 32'h0,   1'b1, 32'h08,  1'b1, 32'h00);
    tbl[3]  = v(1'b1, 1'b0, 32'h0,   1'b1, 32'h0C,  1'b1, 32'h04);
    tbl[4]  = v(1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h08);
    tbl[5]  = v(1'b1, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'h0C);
    tbl[6]  = v(1'b0, 1'b0, 32'h0,   1'b1, 32'h18,  1'b1, 32'h10);
    tbl[7]  = v(1'b0, 1'b0, 32'h0,   1'b1, 32'h1C,  1'b1, 32'h10);
    tbl[8]  = v(1'b0, 1'b1, 32'h40,  1'b0, 32'h20,  1'b1, 32'h10);
    tbl[9]  = v(1'b1, 1'b0, 32'h0,   1'b1, 32'h40,  1'b0, 32'h0);
    tbl[10] = v(1'b1, 1'b0, 32'h0,   1'b1, 32'h44,  1'b0, 32'h0);
    tbl[11] = v(1'b1, 1'b0, 32'h0,   1'b1, 32'h48,  1'b1, 32'h40);
    tbl[12] = v(1'b1, 1'b1, 32'h100, 1'b0, 32'h4C,  1'b1, 32'h44);
    tbl[13] = v(1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0);
    tbl[14] = v(1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0);
    tbl[15] = v(1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100);

    #1 rst_n = 1'b0;
    #2 chk_reset_outputs("por");

    // Startup stream, stall to 3 entries, redirect, redirect with response+pop.
    @(posedge clk); #1 rst_n = 1'b1;
    apply_rows(0, 15);

    // PC wrap-around through a redirect to 0xFFFF_FFF8.
    wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000;
    ready = 1'b1; redirect = 1'b1; rpc = 32'hFFFF_FFF8;
    @(posedge clk); #1 redirect = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (j < 3) begin
        chk($sformatf("wrap_req%0d", j), 32'(req), 32'd1);
        chk($sformatf("wrap_addr%0d", j), addr, wexp[j]);
      end
      if (j >= 2) begin
        chk($sformatf("wrap_valid%0d", j), 32'(valid), 32'd1);
        chk($sformatf("wrap_pc%0d", j), hpc, wexp[j-2]);
        chk($sformatf("wrap_instr%0d", j), hinstr, rom_word(wexp[j-2]));
      end
      @(posedge clk); #1;
    end

    // Asynchronous reset between clock edges, then a clean restart.
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    @(posedge clk); #1 rst_n = 1'b1;
    apply_rows(0, 5);

    // Decode stalled: exactly DEPTH requests, then an in-order drain.
    rst_n = 1'b0; ready = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    nreq = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      nreq += int'(req);
      @(posedge clk); #1;
    end
    chk("stall_reqs", 32'(nreq), 32'(DEPTH));
    ready = 1'b1;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (valid && k <= int'(DEPTH)) begin
        chk($sformatf("drain_pc%0d", k), hpc, 32'(4 * k));
        chk($sformatf("drain_instr%0d", k), hinstr, rom_word(32'(4 * k)));
        k++;
      end
      @(posedge clk); #1;
    end
    chk("drain_count", 32'(k), 32'(DEPTH + 1));

    // Randomized traffic against the reference model.
    rst_n = 1'b0; ready = 1'b0; redirect = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    mon_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      ready    = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 15) == 0);
      rpc      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
      @(posedge clk); #1;
    end
    mon_en = 1'b0;
    redirect = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
